// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the bin_to_bcd converter.
// Imported by the digit adjuster and the top level.
package bin_to_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] ADJ_TH  = 4'd5;
  localparam logic [3:0] ADJ_INC = 4'd3;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// start/done handshake bundle between a requester
// and the binary-to-BCD converter.
interface bin_to_bcd_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
// Purely combinational, 4-bit wrap.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= ADJ_TH) q = d + ADJ_INC;
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter,
// one input bit per clock under a start/done handshake.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic clk,
  input  logic rst_n,
  bin_to_bcd_if.slave io
);

  localparam int BW = 4 * DIGITS;
  localparam int W  = BW + BIN_W;
  localparam int CW = cnt_w(BIN_W);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  state_t          state, state_n;
  logic [W-1:0]    work, work_n;
  logic [W-1:0]    adj_w, sh_w;
  logic [CW-1:0]   cnt, cnt_n;
  logic            acc, acc_n;
  logic            out_bit;
  logic [BW-1:0]   bcd_q, bcd_n;
  logic            ovf_q, ovf_n;
  logic            done_q, done_n;
  logic            busy_q, busy_n;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (work[BIN_W+4*k +: 4]),
      .q (adj_w[BIN_W+4*k +: 4])
    );
  end

  assign adj_w[BIN_W-1:0] = work[BIN_W-1:0];
  assign sh_w    = {adj_w[W-2:0], 1'b0};
  assign out_bit = adj_w[W-1];

  always_comb begin
    state_n = state;
    work_n  = work;
    cnt_n   = cnt;
    acc_n   = acc;
    bcd_n   = bcd_q;
    ovf_n   = ovf_q;
    done_n  = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (io.start) begin
          state_n = SHIFT;
          work_n  = {{BW{1'b0}}, io.bin};
          cnt_n   = '0;
          acc_n   = 1'b0;
        end
      end
      (state == SHIFT): begin
        work_n = sh_w;
        cnt_n  = cnt + CW'(1);
        acc_n  = acc | out_bit;
        if (cnt == LAST) begin
          state_n = IDLE;
          bcd_n   = sh_w[W-1 -: BW];
          ovf_n   = acc | out_bit;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      acc    <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      bcd_q  <= bcd_n;
      ovf_q  <= ovf_n;
      done_q <= done_n;
      busy_q <= busy_n;
    end
  end

  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.bcd      = bcd_q;
  assign io.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed and random checks of bin_to_bcd with 5 and 3 digits,
// against a decimal-arithmetic reference model.
module tb_bin_to_bcd;

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_if #(.BIN_W(16), .DIGITS(5)) io5 ();
  bin_to_bcd_if #(.BIN_W(16), .DIGITS(3)) io3 ();

  bin_to_bcd #(.BIN_W(16), .DIGITS(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io5.slave)
  );

  bin_to_bcd #(.BIN_W(16), .DIGITS(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io3.slave)
  );

  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int nd);
    int lim;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    return v >= lim;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [15:0] v);
    io5.start = s;
    io5.bin   = v;
    io3.start = s;
    io3.bin   = v;
  endtask

  // Called 1 time unit after an edge; returns cycles from the
  // accepting edge to done (-1 on timeout) and busy samples seen.
  task automatic convert(input logic [15:0] v, output int lat,
                         output int bcnt);
    drive(1'b1, v);
    @(posedge clk);
    #1;
    drive(1'b0, v);
    lat  = -1;
    bcnt = io5.busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (io5.done) begin
        lat = i;
        break;
      end
      if (io5.busy) bcnt++;
    end
  endtask

  task automatic check_both(input string tag, input int v);
    check({tag, "_bcd5"}, 32'(io5.bcd), ref_bcd(v, 5));
    check({tag, "_ovf5"}, 32'(io5.overflow), 32'(ref_ovf(v, 5)));
    check({tag, "_bcd3"}, 32'(io3.bcd), ref_bcd(v, 3));
    check({tag, "_ovf3"}, 32'(io3.overflow), 32'(ref_ovf(v, 3)));
    check({tag, "_done3"}, 32'(io3.done), 32'd1);
  endtask

  initial begin
    int lat, bcnt, ndone, v;
    logic [19:0] b;
    rst_n = 1'b0;
    drive(1'b0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(io5.busy), 32'd0);
    check("rst_done", 32'(io5.done), 32'd0);
    check("rst_bcd", 32'(io5.bcd), 32'd0);
    check("rst_ovf", 32'(io5.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    convert(16'd0, lat, bcnt);
    check("zero_lat", 32'(lat), 32'd16);
    check("zero_busy_cycles", 32'(bcnt), 32'd16);
    check("zero_busy_at_done", 32'(io5.busy), 32'd0);
    check_both("zero", 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(io5.done), 32'd0);

    convert(16'd65535, lat, bcnt);
    check("max_lat", 32'(lat), 32'd16);
    check_both("max", 65535);
    convert(16'd9999, lat, bcnt);
    check_both("n9999", 9999);
    convert(16'd1234, lat, bcnt);
    check_both("n1234", 1234);
    convert(16'd999, lat, bcnt);
    check_both("n999", 999);

    // Ignored start while busy, then start taken in the done cycle.
    drive(1'b1, 16'd42);
    @(posedge clk);
    #1;
    drive(1'b0, 16'd42);
    repeat (3) @(posedge clk);
    #1;
    drive(1'b1, 16'd7);
    @(posedge clk);
    #1;
    drive(1'b0, 16'd7);
    ndone = 0;
    lat = -1;
    for (int i = 5; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (io5.done) begin
        ndone++;
        lat = i;
        break;
      end
    end
    check("hs_first_lat", 32'(lat), 32'd16);
    check("hs_first_bcd", 32'(io5.bcd), 32'h00042);
    convert(16'd7, lat, bcnt);
    check("hs_second_lat", 32'(lat), 32'd16);
    check("hs_second_bcd", 32'(io5.bcd), 32'h00007);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (io5.done) ndone++;
    end
    check("hs_no_extra_done", 32'(ndone), 32'd1);

    // Continuous start: one conversion per 17 cycles.
    drive(1'b1, 16'd123);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (io5.done) break;
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (io5.done) begin
        lat = i;
        break;
      end
    end
    drive(1'b0, 16'd123);
    check("cont_period", 32'(lat), 32'd17);
    check("cont_bcd", 32'(io5.bcd), 32'h00123);
    @(posedge clk);
    #1;
    check("cont_stop_busy", 32'(io5.busy), 32'd0);

    // Reset mid-conversion.
    drive(1'b1, 16'd500);
    @(posedge clk);
    #1;
    drive(1'b0, 16'd500);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(io5.busy), 32'd0);
    check("mid_rst_done", 32'(io5.done), 32'd0);
    check("mid_rst_bcd", 32'(io5.bcd), 32'd0);
    ndone = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (io5.done) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    convert(16'd500, lat, bcnt);
    check("after_rst_lat", 32'(lat), 32'd16);
    check_both("after_rst", 500);

    for (int n = 0; n < 1000; n++) begin
      v = int'($urandom_range(65535, 0));
      convert(16'(v), lat, bcnt);
      check("rnd_lat", 32'(lat), 32'd16);
      check_both("rnd", v);
      b = io5.bcd;
      for (int k = 0; k < 5; k++)
        check("rnd_digit_le9", 32'(b[4*k +: 4] <= 4'd9), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It produces packed BCD digits for the 7-segment digit decoders on the display path. It converts register and ALU values into decimal for the board display, one bit per clock, under a start/done handshake.

## Interface
- BIN_W, 16, width of the binary input.
- DIGITS, 5, number of BCD digits produced; 5 covers the full 16-bit range.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when idle.
- bin  in  BIN_W  unsigned value; captured on the edge that accepts start.
- busy  out  1  conversion in progress.
- done  out  1  single-cycle pulse; bcd and overflow are valid and updated.
- bcd  out  4*DIGITS  packed result; digit 0 (units) in bits [3:0], digit k in [4k+3:4k].
- overflow  out  1  value did not fit in DIGITS digits.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: if start=1, load the working register with {DIGITS*4 zero bits, bin}, clear the iteration counter, clear the internal overflow accumulator, and go to SHIFT. Otherwise hold.
- SHIFT: one iteration per cycle, BIN_W iterations in total.
  - Each iteration first adjusts every digit of the BCD field: if digit ≥ 5, add 3 (4-bit, no carry out).
  - It then shifts the whole register left by 1.
  - The bit shifted out of the top digit's MSB is ORed into the overflow accumulator.
- On the final iteration, the following happen on the same edge:
  - bcd ← adjusted-and-shifted BCD field.
  - overflow ← accumulator, including this iteration's shifted-out bit.
  - done ← 1.
  - State ← IDLE.
- Result on overflow: bcd = bin mod 10^DIGITS, and overflow=1. With default parameters, overflow is always 0.
- bcd and overflow hold their last result until the next completion. They are not cleared by start.
- start while busy=1 is ignored. It is not queued and bin is not re-sampled.
- Digit values are always 0–9. Codes 10–15 never appear on bcd.

## Timing
- Reset values: state IDLE, busy=0, done=0, bcd=0, overflow=0, working register 0, counter 0.
- Reset asserted mid-conversion aborts immediately. No done pulse is produced and outputs take their reset values.
- start is sampled at edge E0.
  - busy is 1 from after E0 until after E_BIN_W, i.e. BIN_W cycles.
  - bcd, overflow and done update at E_BIN_W.
  - done is high for exactly one cycle and drops at E_BIN_W+1.
- busy falls on the same edge at which done rises. The FSM is in IDLE during the done cycle.
- Back-to-back operation:
  - start asserted during the done cycle is accepted.
  - Sustained throughput is one conversion per BIN_W+1 cycles.
- start held high continuously restarts a conversion in every IDLE cycle, i.e. in each done cycle.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- Shared package bin_to_bcd_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - the adjust threshold (5) and increment (3) as named constants;
  - a function computing the counter width, clog2(BIN_W+1).
- Sub-module bcd_digit_adj is natural: purely combinational, a 4-bit digit in and the adjusted digit out. It is instantiated DIGITS times in a generate loop.
- The top level holds the FSM, the iteration counter, the working register of width 4*DIGITS+BIN_W, and the output registers.

## Test plan
- Zero: with bin=0 and a start pulse, done is asserted exactly 16 cycles after the start edge, with bcd=20'h00000, overflow=0, and busy high for 16 cycles.
- Maximum: with bin=16'd65535, bcd=20'h65535 and overflow=0. With bin=16'd9999, bcd=20'h09999.
- Overflow: with DIGITS=3 and bin=16'd1234, bcd=12'h234 and overflow=1. With bin=16'd999, bcd=12'h999 and overflow=0.
- Handshake:
  - Start with bin=42. While busy, pulse start with bin=7. There is exactly one done, and bcd=20'h00042.
  - Then assert start during the done cycle with bin=7. A second done follows 16 cycles later with bcd=20'h00007.
- Reset mid-operation:
  - Start with bin=500 and drop rst_n at cycle 8. busy, done and bcd are 0 immediately, and no done pulse follows.
  - After release, a fresh start with bin=500 yields bcd=20'h00500.
- Random: 1000 random bin values, each compared against a reference model of decimal digits. Every result digit must be ≤ 9.
